pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised, elastic pipeline stage register for the RISC-8 datapath, the successor to the fixed ID/EX latch. It carries an operand/control/destination payload between two stages with a valid/ready handshake, a two-entry skid buffer so `in_ready` never depends combinationally on `out_ready`, and a synchronous flush for branch/hazard squash. Any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) can use it by changing its parameters.

## Interface
- `DATA_W`, 8, width of one operand word
- `NUM_DATA`, 3, number of operand words carried (e.g. rs1, rs2, imm)
- `CTRL_W`, 7, control bundle width (alu_op[2:0], mem_read, mem_write, reg_write, mem_to_reg)
- `RD_W`, 3, destination register index width
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `flush`  in  1  synchronous squash of all held entries
- `in_valid`  in  1  upstream payload valid
- `in_ready`  out  1  stage can accept; registered
- `in_data`  in  NUM_DATA*DATA_W  operand words, word k at [k*DATA_W +: DATA_W]
- `in_ctrl`  in  CTRL_W  control bundle
- `in_rd`  in  RD_W  destination index
- `out_valid`  out  1  payload valid to downstream
- `out_ready`  in  1  downstream accepts
- `out_data`  out  NUM_DATA*DATA_W  held operands
- `out_ctrl`  out  CTRL_W  held control; all-zero whenever `out_valid`=0
- `out_rd`  out  RD_W  held destination index
- `stall_cnt`  out  16  backpressure cycle count (only with `PIPE_STAGE_PERF_EN`)

## Operation
- Storage: main entry M (drives outputs) and skid entry S, each with its own valid bit.
- States: EMPTY (M,S invalid), ONE (M valid), FULL (M,S valid).
- Upstream transfer: `in_valid && in_ready`. Downstream transfer: `out_valid && out_ready`.
- EMPTY: accepted input loads M -> ONE.
- ONE, downstream transfer and accepted input: M reloads -> ONE. Downstream transfer only -> EMPTY. Input only -> M holds, input loads S -> FULL. Neither -> hold.
- FULL: `in_ready`=0. Downstream transfer moves S into M -> ONE. No transfer -> hold.
- `in_ready` = registered `!S.valid`. It is 1 in EMPTY and ONE and 0 in FULL.
- `out_valid` = M.valid. When `out_valid`=0, `out_ctrl` is forced to 0, so the stage presents a bubble with no write side effects. `out_data` and `out_rd` are don't-care in that case, but the implementation drives the last M contents.
- Flush: on a clock edge with `flush`=1, both valid bits clear -> EMPTY. Any input presented in that cycle is dropped. `in_ready` is 1 in the next cycle. Flush has priority over every transfer.
- Payload fields are stored unmodified; there is no arithmetic on the data path.

## Timing
- Latency 1 cycle from accepted input to `out_valid`. Throughput 1 payload/cycle when `out_ready` is held at 1.
- No combinational path from `out_ready` to `in_ready`, or from any input to any output.
- Reset (`reset_n`=0, asynchronous):
  - `out_valid`=0, `out_ctrl`=0, `out_data`=0, `out_rd`=0.
  - `in_ready`=1, `stall_cnt`=0.
  - Deassertion of `reset_n` is synchronous to `clk`.
- Reset mid-operation discards both entries immediately, without waiting for a clock edge.
- Payload order is strictly FIFO. S is never presented before M.

## Configuration
- `PIPE_STAGE_PERF_EN` defined:
  - `stall_cnt` increments on every cycle with `out_valid && !out_ready`.
  - It saturates at 16'hFFFF and clears only on reset.
  - `flush` does not clear it.
- Not defined: the `stall_cnt` port is absent and the counter logic is not compiled.

## Test plan
- Reset: `reset_n` low mid-transfer -> `out_valid`=0, `out_ctrl`=0, `in_ready`=1 immediately, with no clock edge required.
- Streaming: `out_ready`=1, 8 back-to-back payloads (in_data=24'h0A0B0C+k) -> each appears 1 cycle later, in order, `in_ready` stays 1.
- Backpressure: `out_ready`=0, send P0 then P1 -> FULL, `in_ready`=0, P2 held upstream. Release `out_ready` -> P0, P1, P2 appear in order with no loss or duplicate.
- Flush in FULL, with `in_valid`=1 carrying P3 in the same cycle -> next cycle `out_valid`=0, `out_ctrl`=0, `in_ready`=1. P3 never appears.
- Bubble: `in_valid`=0 with `in_ctrl`=7'h7F -> `out_ctrl`=0 while `out_valid`=0.
- With `PIPE_STAGE_PERF_EN`: hold `out_valid`=1 and `out_ready`=0 for 10 cycles -> `stall_cnt`=10. Preload the count to near-max by running 70000 stall cycles -> `stall_cnt` holds at 16'hFFFF.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register with a two-entry skid buffer and synchronous flush.
// Optional backpressure counter on stall_cnt is compiled only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg #(
    parameter int DATA_W   = 8,
    parameter int NUM_DATA = 3,
    parameter int CTRL_W   = 7,
    parameter int RD_W     = 3
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_DATA*DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic [RD_W-1:0]            in_rd,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_DATA*DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [RD_W-1:0]            out_rd
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [15:0]                stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic in_ready_reg;
    logic m_valid;
    logic up_xfer;
    logic dn_xfer;
    logic load_m_in;
    logic load_m_skid;
    logic load_s;

    logic [DATA_W-1:0] m_word_reg [NUM_DATA];
    logic [DATA_W-1:0] s_word_reg [NUM_DATA];
    logic [CTRL_W-1:0] m_ctrl_reg, s_ctrl_reg;
    logic [RD_W-1:0]   m_rd_reg,   s_rd_reg;

    assign m_valid   = (state_reg != ST_EMPTY);
    assign out_valid = m_valid;
    assign in_ready  = in_ready_reg;
    assign up_xfer   = in_valid && in_ready_reg;
    assign dn_xfer   = m_valid && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_EMPTY;
            in_ready_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            in_ready_reg <= (state_next != ST_FULL);
        end
    end

    // Flush overrides every transfer; in FULL in_ready is 0 so up_xfer cannot fire.
    always_comb begin
        state_next  = state_reg;
        load_m_in   = 1'b0;
        load_m_skid = 1'b0;
        load_s      = 1'b0;
        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (up_xfer) begin
                        load_m_in  = 1'b1;
                        state_next = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (dn_xfer && up_xfer) begin
                        load_m_in = 1'b1;
                    end else if (dn_xfer) begin
                        state_next = ST_EMPTY;
                    end else if (up_xfer) begin
                        load_s     = 1'b1;
                        state_next = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (dn_xfer) begin
                        load_m_skid = 1'b1;
                        state_next  = ST_ONE;
                    end
                end
                default: state_next = ST_EMPTY;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DATA; gi++) begin : g_word
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    m_word_reg[gi] <= '0;
                    s_word_reg[gi] <= '0;
                end else begin
                    if (load_m_in) begin
                        m_word_reg[gi] <= in_data[gi*DATA_W +: DATA_W];
                    end else if (load_m_skid) begin
                        m_word_reg[gi] <= s_word_reg[gi];
                    end
                    if (load_s) begin
                        s_word_reg[gi] <= in_data[gi*DATA_W +: DATA_W];
                    end
                end
            end
            assign out_data[gi*DATA_W +: DATA_W] = m_word_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_ctrl_reg <= '0;
            m_rd_reg   <= '0;
            s_ctrl_reg <= '0;
            s_rd_reg   <= '0;
        end else begin
            if (load_m_in) begin
                m_ctrl_reg <= in_ctrl;
                m_rd_reg   <= in_rd;
            end else if (load_m_skid) begin
                m_ctrl_reg <= s_ctrl_reg;
                m_rd_reg   <= s_rd_reg;
            end
            if (load_s) begin
                s_ctrl_reg <= in_ctrl;
                s_rd_reg   <= in_rd;
            end
        end
    end

    // A bubble must carry no write enables downstream.
    assign out_ctrl = m_valid ? m_ctrl_reg : '0;
    assign out_rd   = m_rd_reg;

`ifdef PIPE_STAGE_PERF_EN
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_reg <= '0;
        end else if (m_valid && !out_ready && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed and random steps against a queue-based model.
// Covers the stall counter too when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_reg;

    localparam int DW = 8;
    localparam int ND = 3;
    localparam int CW = 7;
    localparam int RW = 3;

    typedef struct packed {
        logic [ND*DW-1:0] data;
        logic [CW-1:0]    ctrl;
        logic [RW-1:0]    rd;
    } pl_t;

    logic             clk;
    logic             reset_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [ND*DW-1:0] in_data;
    logic [CW-1:0]    in_ctrl;
    logic [RW-1:0]    in_rd;
    logic             out_valid;
    logic             out_ready;
    logic [ND*DW-1:0] out_data;
    logic [CW-1:0]    out_ctrl;
    logic [RW-1:0]    out_rd;
`ifdef PIPE_STAGE_PERF_EN
    logic [15:0]      stall_cnt;
`endif

    pipe_stage_reg #(
        .DATA_W  (DW),
        .NUM_DATA(ND),
        .CTRL_W  (CW),
        .RD_W    (RW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_ctrl  (in_ctrl),
        .in_rd    (in_rd),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ctrl (out_ctrl),
        .out_rd   (out_rd)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the stage is a FIFO of capacity two; in_ready reflects occupancy at cycle start.
    pl_t         q[$];
    int unsigned model_stall;
    int          pass_cnt;
    int          total_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, " out_valid"}, 32'(out_valid), 32'(q.size() > 0));
        chk({tag, " in_ready"}, 32'(in_ready), 32'(q.size() < 2));
        chk({tag, " out_ctrl"}, 32'(out_ctrl), (q.size() > 0) ? 32'(q[0].ctrl) : 32'd0);
        if (q.size() > 0) begin
            chk({tag, " out_data"}, 32'(out_data), 32'(q[0].data));
            chk({tag, " out_rd"}, 32'(out_rd), 32'(q[0].rd));
        end
`ifdef PIPE_STAGE_PERF_EN
        chk({tag, " stall_cnt"}, 32'(stall_cnt), 32'(model_stall));
`endif
    endtask

    function automatic pl_t rnd_pl();
        logic [63:0] r;
        pl_t p;
        r      = {$urandom, $urandom};
        p.data = r[23:0];
        p.ctrl = r[30:24];
        p.rd   = r[33:31];
        return p;
    endfunction

    task automatic step(input string tag, input logic iv, input logic orr, input logic fl, input pl_t p);
        bit acc;
        bit pop;
        in_valid  = iv;
        out_ready = orr;
        flush     = fl;
        in_data   = p.data;
        in_ctrl   = p.ctrl;
        in_rd     = p.rd;
        acc = iv && (q.size() < 2);
        pop = (q.size() > 0) && orr;
        @(posedge clk);
        if ((q.size() > 0) && !orr && (model_stall < 32'd65535)) model_stall++;
        if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(p);
        end
        #1;
        check_outputs(tag);
    endtask

    // Asserts reset mid-cycle and checks outputs before any clock edge arrives.
    task automatic async_reset(input string tag);
        #2 reset_n = 1'b0;
        #1;
        q.delete();
        model_stall = 0;
        chk({tag, " rst out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " rst out_ctrl"}, 32'(out_ctrl), 32'd0);
        chk({tag, " rst in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, " rst out_data"}, 32'(out_data), 32'd0);
        chk({tag, " rst out_rd"}, 32'(out_rd), 32'd0);
`ifdef PIPE_STAGE_PERF_EN
        chk({tag, " rst stall_cnt"}, 32'(stall_cnt), 32'd0);
`endif
        #2 reset_n = 1'b1;
    endtask

    initial begin
        pl_t p;
        pl_t p2;
        bit  sent;
        bit  will_take;
        pass_cnt    = 0;
        total_cnt   = 0;
        model_stall = 0;
        reset_n     = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        in_data     = '0;
        in_ctrl     = '0;
        in_rd       = '0;
        repeat (2) @(posedge clk);
        #3;
        check_outputs("init");
        chk("init out_data", 32'(out_data), 32'd0);
        chk("init out_rd", 32'(out_rd), 32'd0);
        reset_n = 1'b1;

        // Streaming at full throughput.
        for (int k = 0; k < 8; k++) begin
            p      = rnd_pl();
            p.data = 24'h0A0B0C + 24'(k);
            step("stream", 1'b1, 1'b1, 1'b0, p);
        end
        step("stream drain", 1'b0, 1'b1, 1'b0, rnd_pl());
        step("stream idle", 1'b0, 1'b1, 1'b0, rnd_pl());

        // Backpressure: P0, P1 fill the stage, P2 is held upstream until accepted.
        step("bp p0", 1'b1, 1'b0, 1'b0, rnd_pl());
        step("bp p1", 1'b1, 1'b0, 1'b0, rnd_pl());
        p2 = rnd_pl();
        step("bp p2 held", 1'b1, 1'b0, 1'b0, p2);
        step("bp p2 held", 1'b1, 1'b0, 1'b0, p2);
        sent = 1'b0;
        for (int i = 0; i < 6 && !sent; i++) begin
            will_take = (q.size() < 2);
            step("bp release", 1'b1, 1'b1, 1'b0, p2);
            if (will_take) sent = 1'b1;
        end
        chk("bp p2 accepted", 32'(sent), 32'd1);
        for (int i = 0; i < 3; i++) step("bp drain", 1'b0, 1'b1, 1'b0, rnd_pl());

        // Flush while FULL with P3 on the input in the same cycle.
        step("fl fill", 1'b1, 1'b0, 1'b0, rnd_pl());
        step("fl fill", 1'b1, 1'b0, 1'b0, rnd_pl());
        step("flush p3", 1'b1, 1'b0, 1'b1, rnd_pl());
        for (int i = 0; i < 3; i++) step("post flush", 1'b0, 1'b1, 1'b0, rnd_pl());

        // Bubble must show zero control even with all-ones on the input.
        p      = rnd_pl();
        p.ctrl = 7'h7F;
        step("bubble", 1'b0, 1'b1, 1'b0, p);
        step("bubble", 1'b0, 1'b0, 1'b0, p);

        // Reset asserted mid-transfer.
        step("pre rst", 1'b1, 1'b0, 1'b0, rnd_pl());
        step("pre rst", 1'b1, 1'b0, 1'b0, rnd_pl());
        async_reset("mid");

        // Random traffic with occasional flush and one reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) async_reset("rand");
            step("rand", ($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 16) == 0, rnd_pl());
        end

`ifdef PIPE_STAGE_PERF_EN
        async_reset("perf");
        step("perf load", 1'b1, 1'b0, 1'b0, rnd_pl());
        for (int i = 0; i < 10; i++) step("perf stall", 1'b0, 1'b0, 1'b0, rnd_pl());
        chk("perf stall10", 32'(stall_cnt), 32'd10);
        for (int i = 0; i < 70000; i++) step("perf sat", 1'b0, 1'b0, 1'b0, rnd_pl());
        chk("perf saturate", 32'(stall_cnt), 32'h0000FFFF);
        step("perf flush", 1'b0, 1'b0, 1'b1, rnd_pl());
        chk("perf flush keeps", 32'(stall_cnt), 32'h0000FFFF);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
